// File: rtl/pipelined_decode_stage.sv
// Registered RV32I decode stage: valid/ready on both sides, one-cycle latency,
// load-use interlock with a configurable bubble count, illegal flagging and flush.
module pipelined_decode_stage #(
    parameter int XLEN             = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic            shamt_en,
    output logic [2:0]      branch_ctrl,
    output logic            jump_ctrl,
    output logic            reg_write,
    output logic [2:0]      inst_type,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm_out,
    output logic            illegal
);
    localparam int CW = (LOAD_USE_BUBBLES > 0) ? $clog2(LOAD_USE_BUBBLES + 1) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] T_R = 3'b000, T_U = 3'b001, T_LOAD = 3'b010, T_I = 3'b011;
    localparam logic [2:0] T_STORE = 3'b100, T_BR = 3'b101, T_JAL = 3'b110, T_JALR = 3'b111;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011, ALU_SUB = 4'b0100, ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0111, ALU_SLT = 4'b1000, ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [6:0]  w_opcode, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [3:0]  w_alu;
    logic        w_shamt, w_jump, w_rw, w_illegal, w_reads_rs1, w_reads_rs2;
    logic [2:0]  w_br, w_type;
    logic [31:0] w_imm32;
    logic [XLEN-1:0] w_imm_ext;

    assign w_opcode = instr_word[6:0];
    assign w_f3     = instr_word[14:12];
    assign w_f7     = instr_word[31:25];
    assign w_rd     = instr_word[11:7];
    assign w_rs2    = instr_word[24:20];

    always_comb begin
        w_alu       = 4'b0000;
        w_shamt     = 1'b0;
        w_br        = 3'b000;
        w_jump      = 1'b0;
        w_rw        = 1'b0;
        w_type      = T_R;
        w_imm32     = 32'd0;
        w_illegal   = 1'b0;
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        w_rs1       = instr_word[19:15];
        case (w_opcode)
            OP_R: begin
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
                w_rw        = 1'b1;
                w_alu       = alu_of(w_f3, w_f7[5]);
                if (w_f7 != F7_ZERO && w_f7 != F7_ALT)
                    w_illegal = 1'b1;
                else if (w_f7 == F7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101)
                    w_illegal = 1'b1;
            end
            OP_I: begin
                w_type      = T_I;
                w_reads_rs1 = 1'b1;
                w_rw        = 1'b1;
                w_imm32     = {{20{instr_word[31]}}, instr_word[31:20]};
                if (w_f3 == 3'b001) begin
                    w_shamt   = 1'b1;
                    w_alu     = ALU_SLL;
                    w_illegal = (w_f7 != F7_ZERO);
                end else if (w_f3 == 3'b101) begin
                    w_shamt   = 1'b1;
                    w_alu     = w_f7[5] ? ALU_SRA : ALU_SRL;
                    w_illegal = (w_f7 != F7_ZERO && w_f7 != F7_ALT);
                end else begin
                    w_alu = alu_of(w_f3, 1'b0);
                end
            end
            OP_LOAD: begin
                w_type      = T_LOAD;
                w_reads_rs1 = 1'b1;
                w_rw        = 1'b1;
                w_alu       = ALU_ADD;
                w_imm32     = {{20{instr_word[31]}}, instr_word[31:20]};
            end
            OP_STORE: begin
                w_type      = T_STORE;
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
                w_alu       = ALU_ADD;
                w_imm32     = {{20{instr_word[31]}}, instr_word[31:25], instr_word[11:7]};
            end
            OP_BR: begin
                w_type      = T_BR;
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
                w_alu       = ALU_SUB;
                w_imm32     = {{19{instr_word[31]}}, instr_word[31], instr_word[7],
                               instr_word[30:25], instr_word[11:8], 1'b0};
                case (w_f3)
                    3'b000:  w_br = 3'b000;
                    3'b001:  w_br = 3'b001;
                    3'b100:  w_br = 3'b010;
                    3'b101:  w_br = 3'b011;
                    3'b110:  w_br = 3'b100;
                    3'b111:  w_br = 3'b101;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                w_type  = T_JAL;
                w_jump  = 1'b1;
                w_rw    = 1'b1;
                w_alu   = ALU_ADD;
                w_imm32 = {{11{instr_word[31]}}, instr_word[31], instr_word[19:12],
                           instr_word[20], instr_word[30:21], 1'b0};
            end
            OP_JALR: begin
                w_type      = T_JALR;
                w_reads_rs1 = 1'b1;
                w_jump      = 1'b1;
                w_rw        = 1'b1;
                w_alu       = ALU_ADD;
                w_imm32     = {{20{instr_word[31]}}, instr_word[31:20]};
            end
            OP_LUI: begin
                w_type  = T_U;
                w_rw    = 1'b1;
                w_alu   = ALU_ADD;
                w_rs1   = 5'd0;
                w_imm32 = {instr_word[31:12], 12'd0};
            end
            OP_AUIPC: begin
                w_type  = T_U;
                w_rw    = 1'b1;
                w_alu   = ALU_ADD;
                w_imm32 = {instr_word[31:12], 12'd0};
            end
            default: w_illegal = 1'b1;
        endcase
        // An illegal word still travels down the pipe, but must not act.
        if (w_illegal) begin
            w_alu  = 4'b0000;
            w_rw   = 1'b0;
            w_jump = 1'b0;
            w_br   = 3'b000;
        end
        if (w_rd == 5'd0)
            w_rw = 1'b0;
    end

    assign w_imm_ext[31:0] = w_imm32;
    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_sext
            assign w_imm_ext[gi] = w_imm32[31];
        end
    endgenerate

    logic          r_out_valid;
    logic [3:0]    r_alu;
    logic          r_shamt, r_jump, r_rw, r_illegal;
    logic [2:0]    r_br, r_type;
    logic [4:0]    r_rd, r_rs1, r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_cnt_rd;

    // Two sources of a pending load result: the held load itself, and the bubble window after it.
    logic [1:0] w_src_live, w_src_hit;
    logic [4:0] w_src_rd [2];
    logic       w_hazard, w_fire_in, w_fire_out;

    assign w_src_live[0] = r_out_valid && (r_type == T_LOAD);
    assign w_src_rd[0]   = r_rd;
    assign w_src_live[1] = (r_cnt != '0);
    assign w_src_rd[1]   = r_cnt_rd;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_haz
            assign w_src_hit[gi] = w_src_live[gi] && (w_src_rd[gi] != 5'd0) &&
                                   ((w_reads_rs1 && w_rs1 == w_src_rd[gi]) ||
                                    (w_reads_rs2 && w_rs2 == w_src_rd[gi]));
        end
    endgenerate

    assign w_hazard   = (LOAD_USE_BUBBLES > 0) && (w_src_hit != 2'b00);
    assign in_ready   = !flush && (!r_out_valid || out_ready) && !w_hazard;
    assign w_fire_in  = in_valid && in_ready;
    assign w_fire_out = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu       <= '0;
            r_shamt     <= 1'b0;
            r_jump      <= 1'b0;
            r_rw        <= 1'b0;
            r_illegal   <= 1'b0;
            r_br        <= '0;
            r_type      <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_cnt       <= '0;
            r_cnt_rd    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_fire_in) begin
                r_out_valid <= 1'b1;
                r_alu       <= w_alu;
                r_shamt     <= w_shamt;
                r_jump      <= w_jump;
                r_rw        <= w_rw;
                r_illegal   <= w_illegal;
                r_br        <= w_br;
                r_type      <= w_type;
                r_rd        <= w_rd;
                r_rs1       <= w_rs1;
                r_rs2       <= w_rs2;
                r_imm       <= w_imm_ext;
            end else if (w_fire_out) begin
                r_out_valid <= 1'b0;
            end
            if (w_fire_out && r_type == T_LOAD && LOAD_USE_BUBBLES > 0) begin
                r_cnt    <= CW'(LOAD_USE_BUBBLES);
                r_cnt_rd <= r_rd;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_ctrl    = r_alu;
    assign shamt_en    = r_shamt;
    assign branch_ctrl = r_br;
    assign jump_ctrl   = r_jump;
    assign reg_write   = r_rw;
    assign inst_type   = r_type;
    assign rd          = r_rd;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign imm_out     = r_imm;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: hand-decoded RV32I words, handshake,
// load-use interlock, backpressure, illegal words, flush and asynchronous reset.
module tb_pipelined_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr_word;
    logic [3:0]  alu_ctrl;
    logic        shamt_en, jump_ctrl, reg_write, illegal;
    logic [2:0]  branch_ctrl, inst_type;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_out;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h40435293;  // srai x5,x6,4
    localparam logic [31:0] I_LW    = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_DEP   = 32'h00728333;  // add  x6,x5,x7
    localparam logic [31:0] I_IND   = 32'h00740333;  // add  x6,x8,x7
    localparam logic [31:0] I_BEQ   = 32'hFE000CE3;  // beq  x0,x0,-8
    localparam logic [31:0] I_BAD   = 32'h000001FF;  // opcode 0x7F, rd=3
    localparam logic [31:0] I_BADF7 = 32'h4020E1B3;  // funct7 0100000, funct3 110
    localparam logic [31:0] I_ADDI0 = 32'h00100013;  // addi x0,x0,1
    localparam logic [31:0] I_JAL   = 32'h008000EF;  // jal  x1,+8
    localparam logic [31:0] I_LUI   = 32'h123453B7;  // lui  x7,0x12345

    pipelined_decode_stage #(.XLEN(32), .LOAD_USE_BUBBLES(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_word(instr_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .shamt_en(shamt_en), .branch_ctrl(branch_ctrl),
        .jump_ctrl(jump_ctrl), .reg_write(reg_write), .inst_type(inst_type),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm_out(imm_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%h", tag, got);
        end else begin
            $display("FAIL %-14s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, confirm it is accepted, and leave the input idle.
    task automatic send(input logic [31:0] w);
        in_valid   = 1'b1;
        instr_word = w;
        #1;
        check("send_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr_word = 32'd0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu",   {28'd0, alu_ctrl}, 32'd0);
        check("rst_imm",   imm_out, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        send(I_ADD);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_alu",   {28'd0, alu_ctrl}, 32'h2);
        check("add_type",  {29'd0, inst_type}, 32'h0);
        check("add_rw",    {31'd0, reg_write}, 32'd1);
        check("add_rd",    {27'd0, rd}, 32'd3);
        check("add_rs",    {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
        check("add_imm",   imm_out, 32'd0);
        tick();
        check("add_drain", {31'd0, out_valid}, 32'd0);

        send(I_SRAI);
        check("srai_alu",   {28'd0, alu_ctrl}, 32'h9);
        check("srai_shamt", {31'd0, shamt_en}, 32'd1);
        check("srai_imm",   imm_out, 32'h0000_0404);
        check("srai_type",  {29'd0, inst_type}, 32'h3);
        check("srai_ill",   {31'd0, illegal}, 32'd0);
        tick();

        // Load-use: stall while the load is held, plus one bubble.
        send(I_LW);
        in_valid = 1'b1; instr_word = I_DEP;
        #1;
        check("lw_type",   {29'd0, inst_type}, 32'h2);
        check("lw_alu",    {28'd0, alu_ctrl}, 32'h2);
        check("lu_stall0", {31'd0, in_ready}, 32'd0);
        tick();
        check("lu_bubble", {31'd0, out_valid}, 32'd0);
        check("lu_stall1", {31'd0, in_ready}, 32'd0);
        tick();
        check("lu_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("dep_valid", {31'd0, out_valid}, 32'd1);
        check("dep_rs1",   {27'd0, rs1}, 32'd5);
        tick();

        // Independent instruction right behind a load is not stalled.
        send(I_LW);
        in_valid = 1'b1; instr_word = I_IND;
        #1;
        check("ind_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("ind_valid", {31'd0, out_valid}, 32'd1);
        check("ind_rs1",   {27'd0, rs1}, 32'd8);
        tick();
        tick();

        // Backpressure: fields stable, nothing new accepted.
        out_ready = 1'b0;
        send(I_BEQ);
        in_valid = 1'b1; instr_word = I_ADD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("beq_valid", {31'd0, out_valid}, 32'd1);
            check("beq_imm",   imm_out, 32'hFFFF_FFF8);
            check("beq_alu",   {28'd0, alu_ctrl}, 32'h4);
            check("beq_type",  {29'd0, inst_type}, 32'h5);
            check("beq_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("beq_drain", {31'd0, out_valid}, 32'd0);

        send(I_BAD);
        check("bad_ill", {31'd0, illegal}, 32'd1);
        check("bad_rw",  {31'd0, reg_write}, 32'd0);
        check("bad_val", {31'd0, out_valid}, 32'd1);
        tick();
        send(I_BADF7);
        check("badf7_ill", {31'd0, illegal}, 32'd1);
        check("badf7_rw",  {31'd0, reg_write}, 32'd0);
        check("badf7_alu", {28'd0, alu_ctrl}, 32'h0);
        tick();

        send(I_ADDI0);
        check("x0_rw",  {31'd0, reg_write}, 32'd0);
        check("x0_imm", imm_out, 32'd1);
        tick();
        send(I_JAL);
        check("jal_jump", {31'd0, jump_ctrl}, 32'd1);
        check("jal_rw",   {31'd0, reg_write}, 32'd1);
        check("jal_type", {29'd0, inst_type}, 32'h6);
        check("jal_imm",  imm_out, 32'd8);
        tick();
        send(I_LUI);
        check("lui_rs1",  {27'd0, rs1}, 32'd0);
        check("lui_imm",  imm_out, 32'h1234_5000);
        check("lui_type", {29'd0, inst_type}, 32'h1);
        tick();

        // Flush with an instruction held and a bubble pending.
        send(I_LW);
        in_valid = 1'b1; instr_word = I_IND;
        tick();
        out_ready = 1'b0;
        flush = 1'b1; instr_word = I_DEP;
        #1;
        check("fl_held", {31'd0, out_valid}, 32'd1);
        check("fl_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_after", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("fl_dep_val", {31'd0, out_valid}, 32'd1);
        check("fl_dep_rs1", {27'd0, rs1}, 32'd5);
        out_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a held transfer.
        out_ready = 1'b0;
        send(I_ADD);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_rd",    {27'd0, rd}, 32'd0);
        rst = 1'b0;
        tick();
        check("arst_noreplay", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
